// File: rtl/in1_debouncer_if.sv
// Bundle of the raw switch input, the debug clear and the conditioned outputs
// handed to the downstream sequence-detector FSM.
interface in1_debouncer_if;
  logic       In1;
  logic       Clr;
  logic       Out1;
  logic       Rise;
  logic       Fall;
  logic [7:0] GlitchCnt;

  modport master (
    output In1,
    output Clr,
    input  Out1,
    input  Rise,
    input  Fall,
    input  GlitchCnt
  );

  modport slave (
    input  In1,
    input  Clr,
    output Out1,
    output Rise,
    output Fall,
    output GlitchCnt
  );
endinterface

// File: rtl/in1_debouncer.sv
// Two-flop synchroniser followed by a four-state stability FSM that accepts a
// new In1 level only after DB_CYCLES consecutive agreeing samples.
module in1_debouncer #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input logic           CLK,
  input logic           RST,
  in1_debouncer_if.slave bus
);

  typedef enum logic [1:0] {
    STABLE_LO,
    PEND_HI,
    STABLE_HI,
    PEND_LO
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out;
  logic             r_rise;
  logic             r_fall;
  logic [7:0]       r_glitch;
  logic             w_glitch;

  // A pending level that reverts before qualifying counts as one rejected glitch.
  assign w_glitch = ((r_state == PEND_HI) && !r_s) ||
                    ((r_state == PEND_LO) &&  r_s);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= 1'b0;
      r_s     <= 1'b0;
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_out   <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= bus.In1;
      r_s     <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      unique case (r_state)
        STABLE_LO: begin
          if (r_s) begin
            r_state <= PEND_HI;
            r_cnt   <= '0;
          end
        end
        PEND_HI: begin
          if (!r_s) begin
            r_state <= STABLE_LO;
          end else if (r_cnt == LP_LAST) begin
            r_state <= STABLE_HI;
            r_out   <= 1'b1;
            r_rise  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!r_s) begin
            r_state <= PEND_LO;
            r_cnt   <= '0;
          end
        end
        PEND_LO: begin
          if (r_s) begin
            r_state <= STABLE_HI;
          end else if (r_cnt == LP_LAST) begin
            r_state <= STABLE_LO;
            r_out   <= 1'b0;
            r_fall  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= STABLE_LO;
          r_out   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_glitch <= 8'd0;
    end else if (bus.Clr) begin
      r_glitch <= 8'd0;
    end else if (w_glitch && (r_glitch != 8'hFF)) begin
      r_glitch <= r_glitch + 8'd1;
    end
  end

  assign bus.Out1      = r_out;
  assign bus.Rise      = r_rise;
  assign bus.Fall      = r_fall;
  assign bus.GlitchCnt = r_glitch;

endmodule

// File: doc/in1_debouncer.md
# in1_debouncer

Input conditioning stage that sits directly upstream of the sequence-detector FSM and drives that FSM's `In1`. It synchronises a raw, asynchronous switch or button level into the `CLK` domain and accepts a new level only after it has been stable for `DB_CYCLES` consecutive cycles. It produces the clean level, one-cycle rise and fall pulses, and a saturating count of rejected glitches for debug.

## Interface
- `DB_CYCLES`, default 4: stability window in cycles; legal range 1 to 2^`CNT_W`-1.
- `CNT_W`, default 8: width of the internal stability counter.
- `CLK`  input  1  system clock; all state updates on the rising edge.
- `RST`  input  1  reset, synchronous and active-high.
- `In1`  input  1  raw asynchronous level (switch/button).
- `Clr`  input  1  synchronous clear of `GlitchCnt`.
- `Out1`  output  1  debounced level; feeds the downstream FSM's `In1`.
- `Rise`  output  1  one-cycle pulse in the cycle `Out1` goes 0→1.
- `Fall`  output  1  one-cycle pulse in the cycle `Out1` goes 1→0.
- `GlitchCnt`  output  8  count of rejected transitions; saturates at 255.

## Operation
- **Synchroniser**
  - Two flops: `sync1 <= In1`, `s <= sync1`.
  - Only `s` is used by the FSM.
- **FSM states and outputs (Moore)**
  - STABLE_LO: `Out1`=0.
  - PEND_HI: `Out1`=0.
  - STABLE_HI: `Out1`=1.
  - PEND_LO: `Out1`=1.
- **STABLE_LO**
  - `s`=1 → PEND_HI, with `cnt`<=0.
  - Otherwise stay.
- **PEND_HI**
  - `s`=0 → STABLE_LO; `GlitchCnt` increments.
  - `s`=1 and `cnt`==`DB_CYCLES`-1 → STABLE_HI; `Rise`=1 for one cycle.
  - `s`=1 otherwise → `cnt`++.
- **STABLE_HI / PEND_LO**
  - Mirror image of the above: PEND_LO is entered on `s`=0.
  - `s`=1 while in PEND_LO → back to STABLE_HI; `GlitchCnt` increments.
  - Qualification in PEND_LO → STABLE_LO; `Fall`=1 for one cycle.
- **Pulse outputs**
  - `Rise` and `Fall` are registered, decoded from the state transition.
  - They are never high together.
  - They are never high for two consecutive cycles.
- **`GlitchCnt`**
  - 8-bit, saturating at 255; it never wraps.
  - `Clr`=1 forces it to 0 on the next edge.
  - `Clr` takes priority over a same-cycle increment; the result is 0.
- **Reset**
  - `RST`=1 at an edge forces, on that edge: `sync1`=`s`=0, STABLE_LO, `cnt`=0, `Out1`=0, `Rise`=`Fall`=0, `GlitchCnt`=0.
  - `RST` has priority over `Clr` and over every FSM transition.
- **Reset mid-operation**
  - A pending qualification is discarded.
  - If `In1` is high when `RST` releases, the block starts from STABLE_LO and re-qualifies. `Out1` rises and `Rise` pulses after the normal latency.

## Timing
- **Edge numbering:** edge 0 is the first rising edge that samples the new `In1` level into `sync1`.
- **Accepted transition:**
  - `s` changes after edge 1.
  - The FSM enters PEND_* after edge 2.
  - `Out1` changes after edge `DB_CYCLES`+2, with `Rise` or `Fall` high in that same cycle.
  - Total latency is `DB_CYCLES`+3 edges.
- **Glitch rejection:**
  - A raw pulse lasting `w` cycles at `In1` is accepted iff `w` >= `DB_CYCLES`+1.
  - Pulses with `w` <= `DB_CYCLES` are rejected.
  - Each rejected pulse adds exactly 1 to `GlitchCnt`, which updates after edge `w`+2.
- **Window restart:** after a rejected glitch, the next change restarts the count from 0. No partial credit is carried over.
- **Reset exit:** the cycle after `RST` deasserts is a normal operating cycle. No extra idle cycle is required.
- **Minimum window:** with `DB_CYCLES`=1, a 2-cycle pulse is accepted and a 1-cycle pulse is rejected.

## Test plan
- **Reset values:** assert `RST` for 3 cycles with `In1`=1 → `Out1`=0, `Rise`=`Fall`=0 and `GlitchCnt`=0 throughout. After release, `Out1`=1 at edge 7 (`DB_CYCLES`=4) with a single `Rise` pulse.
- **Clean press/release:** raise `In1` at edge 0 and hold for 20 cycles, then lower it (`DB_CYCLES`=4) → `Out1` rises after edge 6 and falls 7 edges after the fall is sampled. Exactly one `Rise` and one `Fall` pulse; `GlitchCnt` stays 0.
- **Glitch rejection:** 1-, 3- and 4-cycle high pulses on `In1` with `DB_CYCLES`=4 → `Out1` stays 0 and `GlitchCnt`=3. A following 5-cycle pulse → `Out1` rises, then falls.
- **Saturation and clear:** apply 300 single-cycle glitches → `GlitchCnt`=255, no wrap. Assert `Clr` in the same cycle as a glitch increment → `GlitchCnt`=0.
- **Reset mid-qualification:** assert `RST` for one cycle while in PEND_HI with `cnt`=2 → all outputs 0. With `In1` still high, the full 7-edge latency elapses before `Out1`=1.
- **Bounce burst then settle:** alternate `In1` 0/1 every cycle for 10 cycles, then hold 1 → no `Rise` during the burst. `Rise` fires exactly once, `DB_CYCLES`+3 edges after the last transition is sampled.
